// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states,
// and the lane helpers used when an access is accepted.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    function automatic logic is_misaligned(size_t sz, logic [1:0] off);
        return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_enables(size_t sz, logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << {off[1], 1'b0};
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicating the store data lets the bus pick any lane with bus_be alone.
    function automatic logic [31:0] lane_data(size_t sz, logic [31:0] d);
        case (sz)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-addressed memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_load_extract.sv
// Selects the addressed lanes of a bus read word and right-justifies them,
// sign- or zero-extending to 32 bits.
module mem_load_extract
    import mem_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  addr_lo,
    input  size_t       size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = bus_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lane[addr_lo];
        half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        result   = '0;
        case (size)
            SZ_BYTE: result = {{24{sign & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{sign & half_sel[15]}}, half_sel};
            SZ_WORD: result = bus_rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline load/store unit: turns decoder requests into single bus transactions,
// stalling the pipeline until bus_ack or a bounded timeout.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         mem_size,
    input  logic               mem_sign,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               stall,
    output logic               misalign,
    output logic               bus_err,
    mem_access_unit_if.master  bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t      state_reg;
    logic [CW-1:0] cnt_reg;
    size_t       size_reg;
    logic        sign_reg;
    logic [1:0]  off_reg;
    logic        bus_req_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg;
    logic [3:0]  bus_be_reg;
    logic [31:0] bus_wdata_reg;
    logic [31:0] rdata_reg;
    logic        misalign_reg;
    logic        bus_err_reg;

    size_t       req_size;
    logic        req_valid;
    logic        req_misaligned;
    logic        req_accept;
    logic        timeout;
    logic [31:0] load_result;

    assign req_size       = size_t'(mem_size);
    assign req_valid      = (mem_read | mem_write) && (req_size != SZ_NONE);
    assign req_misaligned = req_valid && is_misaligned(req_size, addr[1:0]);
    assign req_accept     = (state_reg == ST_IDLE) && req_valid && !req_misaligned;
    assign timeout        = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    // Stall must rise in the request cycle itself, so it cannot be registered.
    assign stall = !rst && (req_accept || (state_reg == ST_BUSY));

    mem_load_extract u_extract (
        .bus_rdata (bus.bus_rdata),
        .addr_lo   (off_reg),
        .size      (size_reg),
        .sign      (sign_reg),
        .result    (load_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            size_reg      <= SZ_NONE;
            sign_reg      <= 1'b0;
            off_reg       <= 2'b00;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_be_reg    <= 4'b0000;
            bus_wdata_reg <= '0;
            rdata_reg     <= '0;
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            misalign_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_accept) begin
                        state_reg     <= ST_BUSY;
                        cnt_reg       <= '0;
                        size_reg      <= req_size;
                        sign_reg      <= mem_sign;
                        off_reg       <= addr[1:0];
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= mem_write;
                        bus_addr_reg  <= {addr[31:2], 2'b00};
                        bus_be_reg    <= lane_enables(req_size, addr[1:0]);
                        bus_wdata_reg <= lane_data(req_size, wdata);
                    end else if (req_misaligned) begin
                        misalign_reg <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (bus.bus_ack) begin
                        if (!bus_we_reg) begin
                            rdata_reg <= load_result;
                        end
                        state_reg   <= ST_DONE;
                        bus_req_reg <= 1'b0;
                        bus_we_reg  <= 1'b0;
                        bus_be_reg  <= 4'b0000;
                    end else if (timeout) begin
                        rdata_reg   <= '0;
                        bus_err_reg <= 1'b1;
                        state_reg   <= ST_DONE;
                        bus_req_reg <= 1'b0;
                        bus_we_reg  <= 1'b0;
                        bus_be_reg  <= 4'b0000;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rdata         = rdata_reg;
    assign misalign      = misalign_reg;
    assign bus_err       = bus_err_reg;
    assign bus.bus_req   = bus_req_reg;
    assign bus.bus_we    = bus_we_reg;
    assign bus.bus_addr  = bus_addr_reg;
    assign bus.bus_be    = bus_be_reg;
    assign bus.bus_wdata = bus_wdata_reg;

endmodule
